// File: rtl/instruction_fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_pkg : shared defaults for the fetch stage
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instruction_fetch_queue_pkg;

    localparam int              DEF_XLEN         = 32;
    localparam int              DEF_DEPTH        = 4;
    localparam int              DEF_MAX_INFLIGHT = 2;
    localparam logic [31:0]     DEF_RESET_PC     = 32'h0040_0000;
    localparam logic [31:0]     DEF_IR_NOP       = 32'h0000_0000;

    // Legacy control codes: FLOW = id_ready, STALL = !id_ready, ZERO = redirect to reset PC
    typedef enum logic [1:0] {
        COND_FLOW  = 2'd0,
        COND_STALL = 2'd1,
        COND_ZERO  = 2'd2
    } cond_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_if : redirect, imem request/response and decode ports
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_queue_if
    import instruction_fetch_queue_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_ir;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_npc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, id_ready,
        output imem_req_valid, imem_req_addr, id_valid, id_ir, id_pc, id_npc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, id_ready,
        input  imem_req_valid, imem_req_addr, id_valid, id_ir, id_pc, id_npc
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue_sync_fifo : single-clock FIFO with synchronous clear
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_queue_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       clear,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           din,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           dout,
    output logic      [$clog2(DEPTH):0]     count,
    output logic                            empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst || clear) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst || clear) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue : prefetching fetch stage with redirect and discard
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int              XLEN         = DEF_XLEN,
    parameter int              DEPTH        = DEF_DEPTH,
    parameter int              MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter logic [XLEN-1:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [XLEN-1:0] IR_NOP       = DEF_IR_NOP
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    instruction_fetch_queue_if.master   bus
);
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam int SW = ((OW > IW) ? OW : IW) + 1;
    localparam logic [IW-1:0] MAX_INF = IW'(MAX_INFLIGHT);
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   resp_pc;
    logic [IW-1:0]     inflight;
    logic [IW-1:0]     inflight_next;
    logic [IW-1:0]     discard;
    logic [OW-1:0]     occupancy;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   redirect_aligned;
    logic [XLEN-1:0]   head_pc;
    logic              head_valid;
    logic              req_fire;
    logic              resp_fire;
    logic              push;
    logic              pop;

    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign head_valid       = !fifo_empty && !rst;

    // Every outstanding request holds a FIFO slot so responses can never overflow it
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (inflight < MAX_INF)
                             && ((SW'(occupancy) + SW'(inflight)) < DEPTH_S);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_fire     = bus.imem_resp_valid;
    assign push          = resp_fire && (discard == '0) && !bus.redirect_valid;
    assign pop           = head_valid && bus.id_ready && !bus.redirect_valid;
    assign inflight_next = inflight + IW'(req_fire) - IW'(resp_fire);

    assign head_pc      = head_valid ? head[XLEN-1:0] : '0;
    assign bus.id_valid = head_valid;
    assign bus.id_ir    = head_valid ? head[2*XLEN-1:XLEN] : IR_NOP;
    assign bus.id_pc    = head_pc;
    assign bus.id_npc   = head_pc + XLEN'(4);

    instruction_fetch_queue_sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.redirect_valid),
        .push  (push),
        .din   ({bus.imem_resp_data, resp_pc}),
        .pop   (pop),
        .dout  (head),
        .count (occupancy),
        .empty (fifo_empty)
    );

    // resp_pc tracks the address of the next non-discarded response
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight_next;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                discard  <= inflight_next;
            end else begin
                if (req_fire)                      fetch_pc <= fetch_pc + XLEN'(4);
                if (push)                          resp_pc  <= resp_pc + XLEN'(4);
                if (resp_fire && discard != '0)    discard  <= discard - IW'(1);
            end
        end
    end

    a_resp_tracked: assert property (@(posedge clk) disable iff (rst) !(bus.imem_resp_valid && inflight == '0));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_queue : randomized bench with transaction-level model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          MAXI  = 2;
    localparam logic [31:0] RPC   = 32'h0040_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.XLEN(32)) bus ();

    instruction_fetch_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus knobs and per-cycle overrides
    int          k_lat_lo = 1, k_lat_hi = 1, k_rdy_pct = 100, k_idr_pct = 100, k_redir_pct = 0;
    int          f_idr = -1;
    bit          f_rst = 0, f_redir = 0;
    logic [31:0] f_redir_pc = '0;

    // model state: expected queue of PCs, outstanding requests, next fetch address
    logic [31:0] mq[$];
    pend_t       pend[$];
    logic [31:0] m_fetch_pc = RPC;
    int          last_due = 0;

    int          first_hs = -1, first_idv = -1;
    logic [31:0] first_hs_addr, first_idv_pc, first_idv_npc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        bit          do_rst, do_redir, do_resp, rdy, idr, fire, exp_idv, exp_rv;
        logic [31:0] rpc, exp_pc;
        pend_t       e;
        int          lat, due;
        @(posedge clk);
        #1;
        cyc++;
        do_rst   = f_rst;
        do_redir = !do_rst && (f_redir || ($urandom_range(99) < k_redir_pct));
        rpc      = f_redir ? f_redir_pc : $urandom;
        rdy      = ($urandom_range(99) < k_rdy_pct);
        idr      = (f_idr >= 0) ? (f_idr != 0) : ($urandom_range(99) < k_idr_pct);
        do_resp  = !do_rst && (pend.size() > 0) && (pend[0].due <= cyc);

        rst                 = do_rst;
        bus.redirect_valid  = do_redir;
        bus.redirect_pc     = rpc;
        bus.imem_req_ready  = rdy;
        bus.id_ready        = idr;
        bus.imem_resp_valid = do_resp;
        bus.imem_resp_data  = do_resp ? mem_word(pend[0].addr) : $urandom;
        #1;

        exp_idv = !do_rst && (mq.size() > 0);
        exp_pc  = exp_idv ? mq[0] : 32'h0;
        exp_rv  = !do_rst && !do_redir && (pend.size() < MAXI) && (mq.size() + pend.size() < DEPTH);
        check("id_valid", {31'b0, bus.id_valid}, {31'b0, exp_idv});
        check("id_pc", bus.id_pc, exp_pc);
        check("id_npc", bus.id_npc, exp_pc + 32'd4);
        check("id_ir", bus.id_ir, exp_idv ? mem_word(exp_pc) : 32'h0);
        check("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
        if (!do_rst) check("req_addr", bus.imem_req_addr, m_fetch_pc);

        if (bus.id_valid && first_idv < 0) begin
            first_idv     = cyc;
            first_idv_pc  = bus.id_pc;
            first_idv_npc = bus.id_npc;
        end

        fire = exp_rv && rdy;
        if (fire && first_hs < 0) begin
            first_hs      = cyc;
            first_hs_addr = m_fetch_pc;
        end

        if (do_rst) begin
            mq.delete();
            pend.delete();
            m_fetch_pc = RPC;
            last_due   = 0;
        end else begin
            if (exp_idv && idr && !do_redir) void'(mq.pop_front());
            if (do_resp) begin
                e = pend.pop_front();
                if (!e.stale && !do_redir) mq.push_back(e.addr);
            end
            if (fire) begin
                lat = $urandom_range(k_lat_hi, k_lat_lo);
                due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = due;
                pend.push_back('{addr: m_fetch_pc, due: due, stale: 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (do_redir) begin
                mq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_fetch_pc = {rpc[31:2], 2'b00};
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          cnt;
        bit          hit;
        logic [31:0] p0, held;

        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0;
        bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.id_ready = 0;

        // reset, then steady flow with 1-cycle memory
        f_rst = 1; step(); step(); f_rst = 0;
        check("reset_id_npc", bus.id_npc, 32'h4);
        first_hs = -1; first_idv = -1;
        for (int i = 0; i < 12; i++) step();
        check("first_req_addr", first_hs_addr, 32'h0040_0000);
        check("first_idv_latency", first_idv - first_hs, 2);
        check("first_id_pc", first_idv_pc, 32'h0040_0000);
        check("first_id_npc", first_idv_npc, 32'h0040_0004);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin step(); cnt += bus.id_valid ? 1 : 0; end
        check("sustained_rate", cnt, 8);

        // stall: queue fills to DEPTH, requests stop, head holds
        f_idr = 0;
        for (int i = 0; i < 5; i++) step();
        held = bus.id_pc;
        for (int i = 0; i < 5; i++) step();
        check("stall_buffered", mq.size(), 4);
        check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        check("stall_head_held", bus.id_pc, held);
        f_idr = 1;
        step(); p0 = bus.id_pc;
        check("drain_first", p0, held);
        for (int i = 1; i < 4; i++) begin step(); check("drain_order", bus.id_pc, p0 + 32'(4 * i)); end

        // redirect with two stale requests outstanding (latency 3)
        k_lat_lo = 3; k_lat_hi = 3;
        for (int i = 0; i < 10 && pend.size() != 2; i++) step();
        check("two_inflight", pend.size(), 2);
        f_redir = 1; f_redir_pc = 32'h0040_0103; step(); f_redir = 0;
        step();
        check("redir_req_addr", bus.imem_req_addr, 32'h0040_0100);
        for (int i = 0; i < 20 && !bus.id_valid; i++) step();
        check("redir_first_pc", bus.id_pc, 32'h0040_0100);

        // redirect coinciding with a response and a pop
        k_lat_lo = 1; k_lat_hi = 1; hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc + 1) begin
                f_redir = 1; f_redir_pc = 32'h0040_0200; step(); f_redir = 0;
                step();
                check("redir_resp_pop_idv", {31'b0, bus.id_valid}, 32'h0);
                hit = 1;
            end else begin
                step();
            end
        end
        check("redir_resp_pop_hit", {31'b0, hit}, 32'h1);

        // address wrap at the top of the address space
        f_redir = 1; f_redir_pc = 32'hFFFF_FFFC; step(); f_redir = 0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = bus.imem_req_valid && (bus.imem_req_addr == 32'hFFFF_FFFC);
        end
        step();
        check("wrap_req_addr", bus.imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 20 && !bus.id_valid; i++) step();
        check("wrap_id_pc", bus.id_pc, 32'hFFFF_FFFC);
        check("wrap_id_npc", bus.id_npc, 32'h0000_0000);

        // randomized traffic with redirects and variable latency
        k_lat_lo = 1; k_lat_hi = 4; k_rdy_pct = 50; k_idr_pct = 70; k_redir_pct = 3; f_idr = -1;
        for (int i = 0; i < 2000; i++) step();

        // reset in the middle of the stream
        k_lat_hi = 1; k_rdy_pct = 100; k_idr_pct = 100; k_redir_pct = 0;
        for (int i = 0; i < 6; i++) step();
        f_rst = 1; step(); f_rst = 0;
        step();
        check("post_rst_idv", {31'b0, bus.id_valid}, 32'h0);
        check("post_rst_addr", bus.imem_req_addr, 32'h0040_0000);
        for (int i = 0; i < 6; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
